// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer and its surroundings.
// The slave side is the sequencer; the master side drives decode/memory status.
interface fetch_sequencer_if;
  logic        imem_ack;
  logic        hazard;
  logic        br_valid;
  logic        br_taken;
  logic        jmp_valid;
  logic        halt_req;
  logic        resume;
  logic        imem_req;
  logic        stall;
  logic [1:0]  pc_source;
  logic        flush;
  logic [1:0]  state;
  logic        mem_err;
  logic [15:0] redirect_count;

  modport master (
    output imem_ack, hazard, br_valid, br_taken, jmp_valid, halt_req, resume,
    input  imem_req, stall, pc_source, flush, state, mem_err, redirect_count
  );

  modport slave (
    input  imem_ack, hazard, br_valid, br_taken, jmp_valid, halt_req, resume,
    output imem_req, stall, pc_source, flush, state, mem_err, redirect_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: steers the PC mux, holds the PC on stalls, and keeps
// one pending redirect until the fetch that applies it is accepted.
module fetch_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [1:0]  pend_src_q, pend_src_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic        mem_err_q, mem_err_d;
  logic [15:0] redirect_count_q, redirect_count_d;

  logic [1:0]  redir_src;
  logic        advance;
  logic [1:0]  pc_src;

  // PC-side decisions; the PC samples these on the same edge, so no register
  always_comb begin
    redir_src = 2'd0;
    pc_src    = 2'd0;
    if (bus.jmp_valid) begin
      redir_src = 2'd2;
    end else if (bus.br_valid && bus.br_taken) begin
      redir_src = 2'd1;
    end else begin
      redir_src = 2'd0;
    end
    advance = (state_q == ST_FETCH) && bus.imem_ack && !bus.hazard && !bus.halt_req;
    if (advance) begin
      if (pend_valid_q) begin
        pc_src = pend_src_q;
      end else begin
        pc_src = redir_src;
      end
    end else begin
      pc_src = 2'd0;
    end
  end

  // Next-state, pending capture and counters
  always_comb begin
    state_d          = state_q;
    pend_valid_d     = pend_valid_q;
    pend_src_d       = pend_src_q;
    wait_cnt_d       = wait_cnt_q;
    flush_cnt_d      = flush_cnt_q;
    mem_err_d        = mem_err_q;
    redirect_count_d = redirect_count_q;

    // Only the first redirect is kept; anything after it is wrong-path
    if (advance) begin
      pend_valid_d = 1'b0;
      pend_src_d   = 2'd0;
    end else if (!pend_valid_q && (redir_src != 2'd0)) begin
      pend_valid_d = 1'b1;
      pend_src_d   = redir_src;
    end else begin
      pend_valid_d = pend_valid_q;
    end

    case (state_q)
      ST_FETCH: begin
        if (bus.halt_req) begin
          state_d = ST_HALT;
        end else if (!bus.imem_ack) begin
          state_d    = ST_WAIT;
          wait_cnt_d = 8'd0;
        end else if (bus.hazard) begin
          state_d = ST_FETCH;
        end else if (pc_src != 2'd0) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = 3'd0;
          if (redirect_count_q != 16'hFFFF) begin
            redirect_count_d = redirect_count_q + 16'd1;
          end else begin
            redirect_count_d = redirect_count_q;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (bus.imem_ack) begin
          state_d = ST_FETCH;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_HALT;
          mem_err_d  = 1'b1;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d     = ST_FETCH;
          flush_cnt_d = 3'd0;
        end else begin
          flush_cnt_d = flush_cnt_q + 3'd1;
        end
      end
      ST_HALT: begin
        if (bus.resume) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_FETCH;
      pend_valid_q     <= 1'b0;
      pend_src_q       <= 2'd0;
      wait_cnt_q       <= 8'd0;
      flush_cnt_q      <= 3'd0;
      mem_err_q        <= 1'b0;
      redirect_count_q <= 16'd0;
    end else begin
      state_q          <= state_d;
      pend_valid_q     <= pend_valid_d;
      pend_src_q       <= pend_src_d;
      wait_cnt_q       <= wait_cnt_d;
      flush_cnt_q      <= flush_cnt_d;
      mem_err_q        <= mem_err_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign bus.stall          = !advance;
  assign bus.pc_source      = pc_src;
  assign bus.imem_req       = (state_q == ST_FETCH) || (state_q == ST_WAIT);
  assign bus.flush          = (state_q == ST_FLUSH);
  assign bus.state          = state_q;
  assign bus.mem_err        = mem_err_q;
  assign bus.redirect_count = redirect_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expectations are queued as each step is
// driven, then popped and checked against the DUT mid-cycle.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  localparam int S_STALL = 0, S_PCSRC = 1, S_FLUSH = 2, S_STATE = 3,
                 S_MERR = 4, S_RCNT = 5, S_IREQ = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_STALL: return {15'd0, bus.stall};
      S_PCSRC: return {14'd0, bus.pc_source};
      S_FLUSH: return {15'd0, bus.flush};
      S_STATE: return {14'd0, bus.state};
      S_MERR:  return {15'd0, bus.mem_err};
      S_RCNT:  return bus.redirect_count;
      S_IREQ:  return {15'd0, bus.imem_req};
      default: return 16'hDEAD;
    endcase
  endfunction

  task automatic ex(input string tag, input int sel, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_cmp++;
      assert (obs === e.val)
      else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic drive(input logic ack, input logic haz, input logic brv, input logic brt,
                       input logic jmp, input logic halt, input logic res);
    bus.imem_ack  = ack;
    bus.hazard    = haz;
    bus.br_valid  = brv;
    bus.br_taken  = brt;
    bus.jmp_valid = jmp;
    bus.halt_req  = halt;
    bus.resume    = res;
  endtask

  // One cycle: inputs change on the falling edge, outputs sampled 1 ns later
  task automatic cyc(input logic ack, input logic haz, input logic brv, input logic brt,
                     input logic jmp, input logic halt, input logic res);
    @(negedge clk);
    drive(ack, haz, brv, brt, jmp, halt, res);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    ex("rst state", S_STATE, 16'd0); ex("rst flush", S_FLUSH, 16'd0);
    ex("rst mem_err", S_MERR, 16'd0); ex("rst rcnt", S_RCNT, 16'd0);
    ex("rst imem_req", S_IREQ, 16'd1);
    check_all();

    // Plain sequential fetch
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    ex("seq stall", S_STALL, 16'd0); ex("seq pcsrc", S_PCSRC, 16'd0); ex("seq state", S_STATE, 16'd0);
    check_all();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      ex("seq stall", S_STALL, 16'd0); ex("seq pcsrc", S_PCSRC, 16'd0); ex("seq state", S_STATE, 16'd0);
      check_all();
    end
    ex("seq rcnt", S_RCNT, 16'd0);
    check_all();

    // Taken branch on an advance
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ex("br pcsrc", S_PCSRC, 16'd1); ex("br stall", S_STALL, 16'd0);
    check_all();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      ex("br flush", S_FLUSH, 16'd1); ex("br fl stall", S_STALL, 16'd1);
      ex("br fl state", S_STATE, 16'd2); ex("br fl imem_req", S_IREQ, 16'd0);
      check_all();
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex("br post state", S_STATE, 16'd0); ex("br post flush", S_FLUSH, 16'd0);
    ex("br rcnt", S_RCNT, 16'd1); ex("br post pcsrc", S_PCSRC, 16'd0);
    check_all();

    // Jump captured while waiting, later branch is wrong-path
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex("pend c1 stall", S_STALL, 16'd1); ex("pend c1 state", S_STATE, 16'd0);
    check_all();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ex("pend c2 state", S_STATE, 16'd1); ex("pend c2 stall", S_STALL, 16'd1);
    ex("pend c2 pcsrc", S_PCSRC, 16'd0);
    check_all();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ex("pend c3 state", S_STATE, 16'd1);
    check_all();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex("pend ack state", S_STATE, 16'd1); ex("pend ack stall", S_STALL, 16'd1);
    check_all();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex("pend adv pcsrc", S_PCSRC, 16'd2); ex("pend adv stall", S_STALL, 16'd0);
    check_all();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex("pend flush state", S_STATE, 16'd2); ex("pend rcnt", S_RCNT, 16'd2);
    check_all();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex("pend flush2", S_FLUSH, 16'd1);
    check_all();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex("pend cleared pcsrc", S_PCSRC, 16'd0); ex("pend cleared state", S_STATE, 16'd0);
    check_all();

    // Hazard captures a branch, halt keeps it, resume applies it
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ex("haz stall", S_STALL, 16'd1); ex("haz pcsrc", S_PCSRC, 16'd0);
    check_all();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    ex("haz hold state", S_STATE, 16'd0); ex("halt_req stall", S_STALL, 16'd1);
    ex("halt_req pcsrc", S_PCSRC, 16'd0);
    check_all();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ex("halt state", S_STATE, 16'd3); ex("halt imem_req", S_IREQ, 16'd0);
    ex("halt stall", S_STALL, 16'd1);
    check_all();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex("retained pcsrc", S_PCSRC, 16'd1); ex("retained state", S_STATE, 16'd0);
    check_all();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      ex("retained flush", S_FLUSH, 16'd1);
      check_all();
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex("retained rcnt", S_RCNT, 16'd3); ex("retained post", S_STATE, 16'd0);
    check_all();

    // Memory timeout
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex("to enter state", S_STATE, 16'd0);
    check_all();
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      ex("to wait state", S_STATE, 16'd1); ex("to wait mem_err", S_MERR, 16'd0);
      ex("to wait stall", S_STALL, 16'd1);
      check_all();
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ex("to halt state", S_STATE, 16'd3); ex("to mem_err", S_MERR, 16'd1);
    check_all();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex("resume state", S_STATE, 16'd0); ex("resume mem_err", S_MERR, 16'd1);
    ex("resume stall", S_STALL, 16'd0);
    check_all();

    // Reset in the middle of a flush
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ex("rf jmp pcsrc", S_PCSRC, 16'd2);
    check_all();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex("rf fl1 state", S_STATE, 16'd2); ex("rf rcnt", S_RCNT, 16'd4);
    check_all();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex("rf fl2 flush", S_FLUSH, 16'd1);
    check_all();
    rst = 1'b1;
    #1;
    ex("rf rst state", S_STATE, 16'd0); ex("rf rst flush", S_FLUSH, 16'd0);
    ex("rf rst rcnt", S_RCNT, 16'd0); ex("rf rst mem_err", S_MERR, 16'd0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    ex("rf rel flush", S_FLUSH, 16'd0); ex("rf rel stall", S_STALL, 16'd0);
    check_all();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex("rf after flush", S_FLUSH, 16'd0); ex("rf after state", S_STATE, 16'd0);
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, SHALL set the number of cycles flush is held after a redirect (legal range 1..7).
REQ-002 Parameter MEM_TIMEOUT, default 15, SHALL set the maximum number of cycles spent in WAIT without imem_ack (legal range 1..255).
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 imem_ack  in  1  instruction memory returned the word for the current pc.
REQ-006 hazard  in  1  load-use stall request from decode.
REQ-007 br_valid  in  1  branch resolved this cycle.
REQ-008 br_taken  in  1  resolved branch is taken; SHALL be ignored when br_valid=0.
REQ-009 jmp_valid  in  1  absolute jump resolved this cycle.
REQ-010 halt_req  in  1  request to halt fetch.
REQ-011 resume  in  1  leave HALT.
REQ-012 imem_req  out  1  fetch request to instruction memory.
REQ-013 stall  out  1  PC hold; PC holds when 1.
REQ-014 pc_source  out  2  PC next-value select: 0 = pc+4, 1 = branch offset, 2 = absolute jump; 3 SHALL never be driven.
REQ-015 flush  out  1  kill the younger in-flight instruction.
REQ-016 state  out  2  current FSM state: FETCH=0, WAIT=1, FLUSH=2, HALT=3.
REQ-017 mem_err  out  1  sticky memory-timeout flag.
REQ-018 redirect_count  out  16  number of redirects applied.

Function
REQ-019 stall and pc_source SHALL be combinational from state, pending register and inputs, because the PC samples them on the same edge; all other outputs SHALL be registered or decoded from state only.
REQ-020 imem_req SHALL be 1 in FETCH and WAIT and 0 in FLUSH and HALT.
REQ-021 An "advance" SHALL occur in a cycle where state=FETCH, imem_ack=1, hazard=0 and halt_req=0; stall=0 only on an advance cycle.
REQ-022 Redirect source per cycle: jmp_valid gives 2; else br_valid&br_taken gives 1; else none. Jump SHALL have priority.
REQ-023 On an advance, pc_source SHALL equal the pending source if the pending register is set, else this cycle's redirect source, else 0.
REQ-024 A redirect arriving in a non-advance cycle SHALL be captured into the pending register only if the register is empty; later redirects (wrong-path) SHALL be ignored until it clears.
REQ-025 The pending register SHALL clear on the advance that applies it.
REQ-026 An advance with pc_source≠0 SHALL move the FSM to FLUSH and increment redirect_count, saturating at 16'hFFFF; an advance with pc_source=0 SHALL stay in FETCH.
REQ-027 FETCH with imem_ack=0 and halt_req=0 SHALL move to WAIT and clear the wait counter.
REQ-028 FETCH with halt_req=1 SHALL move to HALT regardless of other inputs, with stall=1; the pending register SHALL be retained.
REQ-029 WAIT SHALL hold stall=1; imem_ack=1 SHALL return to FETCH; otherwise the wait counter increments.
REQ-030 When the wait counter reaches MEM_TIMEOUT without ack, the FSM SHALL go to HALT and set mem_err=1.
REQ-031 FLUSH SHALL assert flush=1 and stall=1 for exactly FLUSH_CYCLES cycles, then go to FETCH.
REQ-032 HALT SHALL hold stall=1; resume=1 SHALL go to FETCH next cycle; resume SHALL NOT clear mem_err.
REQ-033 hazard=1 in FETCH with imem_ack=1 SHALL hold the FSM in FETCH with stall=1.

Reset
REQ-034 rst=1 SHALL immediately, without waiting for a clock edge, force state=FETCH, pending register empty, wait and flush counters=0, flush=0, mem_err=0, redirect_count=0; imem_req=1 follows from FETCH.
REQ-035 Reset asserted mid-WAIT or mid-FLUSH SHALL abandon the operation with no further flush pulse after release.

Verification
REQ-036 Reset release, imem_ack=1 constant for 4 cycles -> stall=0 and pc_source=0 on all 4 cycles, state=0, redirect_count=0.
REQ-037 Advance with br_valid=1 and br_taken=1 -> pc_source=1 that cycle; flush=1 and stall=1 for the next 2 cycles; then state=0; redirect_count=1.
REQ-038 imem_ack=0 for 3 cycles, with jmp_valid pulsed in cycle 2 and br taken in cycle 3, then ack -> on the advance, pc_source=2 (jump applied), branch ignored, FLUSH entered.
REQ-039 imem_ack held 0 -> state=1 for 15 cycles, then state=3 and mem_err=1; resume -> state=0 with mem_err still 1.
REQ-040 rst pulsed during the second FLUSH cycle -> state=0 and flush=0 immediately, redirect_count=0.
